// File: rtl/player_tank_hit.sv
// Player tank hit detection and life cycle: checks enemy bullets against the tank hitbox and
// sequences explosion, respawn, invulnerability and game over in the frame-rate clock domain.
module player_tank_hit #(
    parameter int NUM_BULLETS    = 8,
    parameter int TANK_SIZE      = 30,
    parameter int LIVES_INIT     = 3,
    parameter int EXPLODE_FRAMES = 30,
    parameter int INVULN_FRAMES  = 120,
    parameter int BLINK_SHIFT    = 3
) (
    input  logic                      clk_f,
    input  logic                      rst_n,
    input  logic [9:0]                tank_x,
    input  logic [9:0]                tank_y,
    input  logic [10*NUM_BULLETS-1:0] bullet_x,
    input  logic [10*NUM_BULLETS-1:0] bullet_y,
    input  logic [NUM_BULLETS-1:0]    bullet_exit,
    input  logic                      game_restart,
    output logic                      tank_exit,
    output logic [2:0]                tank_lives,
    output logic                      hit_pulse,
    output logic [NUM_BULLETS-1:0]    bullet_kill,
    output logic                      respawn_req,
    output logic                      blink,
    output logic                      game_over,
    output logic [2:0]                tank_state
);

    localparam int MAX_FRAMES = (INVULN_FRAMES > EXPLODE_FRAMES) ? INVULN_FRAMES : EXPLODE_FRAMES;
    localparam int CNT_BASE_W = $clog2(MAX_FRAMES + 1);
    localparam int CNT_W      = (CNT_BASE_W > BLINK_SHIFT) ? CNT_BASE_W : (BLINK_SHIFT + 1);

    localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST  = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [2:0]       LIVES_LOAD   = 3'(LIVES_INIT);

    typedef enum logic [2:0] {
        ST_ALIVE    = 3'd0,
        ST_EXPLODE  = 3'd1,
        ST_RESPAWN  = 3'd2,
        ST_INVULN   = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic                     tank_exit_q;
    logic [2:0]               lives_q;
    logic                     hit_pulse_q;
    logic [NUM_BULLETS-1:0]   bullet_kill_q;
    logic                     respawn_req_q;
    logic                     blink_q;
    logic                     game_over_q;

    // Hitbox upper bounds are one bit wider so a tank near the right/bottom edge does not wrap.
    logic [10:0]              x_hi_s;
    logic [10:0]              y_hi_s;
    logic [NUM_BULLETS-1:0]   hit_s;

    assign x_hi_s    = {1'b0, tank_x} + 11'(TANK_SIZE);
    assign y_hi_s    = {1'b0, tank_y} + 11'(TANK_SIZE);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Per-bullet overlap test against the tank hitbox.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_s[i] = bullet_exit[i]
                     && (bullet_x[10*i +: 10] >= tank_x)
                     && ({1'b0, bullet_x[10*i +: 10]} < x_hi_s)
                     && (bullet_y[10*i +: 10] >= tank_y)
                     && ({1'b0, bullet_y[10*i +: 10]} < y_hi_s);
        end
    end

    // Tank life-cycle FSM; every output is a register updated here.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ALIVE;
            cnt_q         <= '0;
            tank_exit_q   <= 1'b1;
            lives_q       <= LIVES_LOAD;
            hit_pulse_q   <= 1'b0;
            bullet_kill_q <= '0;
            respawn_req_q <= 1'b0;
            blink_q       <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            hit_pulse_q   <= 1'b0;
            bullet_kill_q <= '0;
            respawn_req_q <= 1'b0;
            case (state_q)
                ST_ALIVE: begin
                    blink_q     <= 1'b0;
                    game_over_q <= 1'b0;
                    if (|hit_s) begin
                        state_q       <= ST_EXPLODE;
                        tank_exit_q   <= 1'b0;
                        lives_q       <= (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);
                        hit_pulse_q   <= 1'b1;
                        bullet_kill_q <= hit_s;
                        cnt_q         <= '0;
                    end
                end
                ST_EXPLODE: begin
                    cnt_q <= cnt_inc_s;
                    if (cnt_q == EXPLODE_LAST) begin
                        if (lives_q == 3'd0) begin
                            state_q     <= ST_GAMEOVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= ST_RESPAWN;
                        end
                    end
                end
                ST_RESPAWN: begin
                    respawn_req_q <= 1'b1;
                    tank_exit_q   <= 1'b1;
                    blink_q       <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= ST_INVULN;
                end
                ST_INVULN: begin
                    // Bullets are absorbed: cleared but never cost a life.
                    bullet_kill_q <= hit_s;
                    if (cnt_q == INVULN_LAST) begin
                        state_q <= ST_ALIVE;
                        blink_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_inc_s;
                        blink_q <= cnt_inc_s[BLINK_SHIFT];
                    end
                end
                ST_GAMEOVER: begin
                    tank_exit_q <= 1'b0;
                    blink_q     <= 1'b0;
                    game_over_q <= 1'b1;
                    if (game_restart) begin
                        lives_q     <= LIVES_LOAD;
                        game_over_q <= 1'b0;
                        state_q     <= ST_RESPAWN;
                    end
                end
                default: begin
                    state_q     <= ST_ALIVE;
                    tank_exit_q <= 1'b1;
                    blink_q     <= 1'b0;
                    game_over_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign tank_exit   = tank_exit_q;
    assign tank_lives  = lives_q;
    assign hit_pulse   = hit_pulse_q;
    assign bullet_kill = bullet_kill_q;
    assign respawn_req = respawn_req_q;
    assign blink       = blink_q;
    assign game_over   = game_over_q;
    assign tank_state  = state_q;

endmodule

// File: tb/tb_player_tank_hit.sv
// Bench for player_tank_hit: directed scenarios plus random play, checked every cycle against a
// timeline model that derives the phase from frames elapsed since the last hit or restart.
module tb_player_tank_hit;

    localparam int NB    = 8;
    localparam int LIVES = 3;

    logic              clk_f = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        tank_x;
    logic [9:0]        tank_y;
    logic [10*NB-1:0]  bullet_x;
    logic [10*NB-1:0]  bullet_y;
    logic [NB-1:0]     bullet_exit;
    logic              game_restart;
    logic              tank_exit;
    logic [2:0]        tank_lives;
    logic              hit_pulse;
    logic [NB-1:0]     bullet_kill;
    logic              respawn_req;
    logic              blink;
    logic              game_over;
    logic [2:0]        tank_state;

    player_tank_hit dut (
        .clk_f(clk_f), .rst_n(rst_n), .tank_x(tank_x), .tank_y(tank_y),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_exit(bullet_exit),
        .game_restart(game_restart), .tank_exit(tank_exit), .tank_lives(tank_lives),
        .hit_pulse(hit_pulse), .bullet_kill(bullet_kill), .respawn_req(respawn_req),
        .blink(blink), .game_over(game_over), .tank_state(tank_state)
    );

    always #5 clk_f = ~clk_f;

    int n_cmp = 0;
    int n_bad = 0;

    int tx, ty;
    int bx[NB];
    int by[NB];
    bit bex[NB];

    // Timeline model: origin = edge of the damaging hit (restart is treated as a hit 30 frames ago).
    int edge_n, origin, lives;
    bit seq_on, go;
    int e_state;
    bit e_exit, e_hit, e_resp, e_blink, e_go;
    logic [NB-1:0] e_kill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int phase();
        int d;
        if (go) return 4;
        if (!seq_on) return 0;
        d = edge_n - origin;
        if (d <= 29) return 1;
        if (d == 30) return 2;
        if (d <= 150) return 3;
        return 0;
    endfunction

    function automatic logic [NB-1:0] hits();
        logic [NB-1:0] h;
        h = '0;
        for (int i = 0; i < NB; i++)
            h[i] = bex[i] && bx[i] >= tx && bx[i] < tx + 30 && by[i] >= ty && by[i] < ty + 30;
        return h;
    endfunction

    task automatic model_reset();
        edge_n = 0; origin = 0; seq_on = 1'b0; go = 1'b0; lives = LIVES;
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < NB; i++) begin bx[i] = 0; by[i] = 0; bex[i] = 1'b0; end
    endtask

    task automatic put(input int i, input int x, input int y);
        bx[i] = x; by[i] = y; bex[i] = 1'b1;
    endtask

    task automatic rand_bullets();
        for (int i = 0; i < NB; i++) begin
            bex[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bx[i] = (tx + $urandom_range(0, 34) - 2) & 1023;
                by[i] = (ty + $urandom_range(0, 34) - 2) & 1023;
            end else begin
                bx[i] = $urandom_range(0, 1023);
                by[i] = $urandom_range(0, 1023);
            end
        end
    endtask

    task automatic apply();
        tank_x = 10'(tx);
        tank_y = 10'(ty);
        for (int i = 0; i < NB; i++) begin
            bullet_x[10*i +: 10] = 10'(bx[i]);
            bullet_y[10*i +: 10] = 10'(by[i]);
            bullet_exit[i]       = bex[i];
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] h;
        int cur, d;
        h = hits();
        cur = phase();
        e_hit = 1'b0;
        e_kill = '0;
        if (cur == 0 && |h) begin
            seq_on = 1'b1; origin = edge_n + 1;
            if (lives > 0) lives--;
            e_hit = 1'b1; e_kill = h;
        end else if (cur == 3) begin
            e_kill = h;
        end else if (cur == 4 && game_restart) begin
            go = 1'b0; seq_on = 1'b1; lives = LIVES; origin = edge_n + 1 - 30;
        end
        edge_n++;
        if (phase() == 2 && lives == 0) go = 1'b1;
        e_state = phase();
        d = edge_n - origin;
        e_exit  = (e_state == 0 || e_state == 3);
        e_go    = (e_state == 4);
        e_resp  = (e_state == 3 && d == 31);
        e_blink = (e_state == 3) ? 1'(((d - 31) >> 3) & 1) : 1'b0;
    endtask

    task automatic cycle();
        apply();
        model_edge();
        @(posedge clk_f);
        @(negedge clk_f);
        chk("state", tank_state, e_state);
        chk("tank_exit", tank_exit, e_exit);
        chk("lives", tank_lives, lives);
        chk("hit_pulse", hit_pulse, e_hit);
        chk("bullet_kill", bullet_kill, e_kill);
        chk("respawn_req", respawn_req, e_resp);
        chk("blink", blink, e_blink);
        chk("game_over", game_over, e_go);
    endtask

    task automatic run_until_alive();
        int guard;
        guard = 0;
        clear_bullets();
        while (phase() != 0 && guard < 400) begin cycle(); guard++; end
        chk("alive_reached", tank_state, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, tank_state, 0);
        chk({tag, "_exit"}, tank_exit, 1);
        chk({tag, "_lives"}, tank_lives, LIVES);
        chk({tag, "_hit"}, hit_pulse, 0);
        chk({tag, "_kill"}, bullet_kill, 0);
        chk({tag, "_resp"}, respawn_req, 0);
        chk({tag, "_blink"}, blink, 0);
        chk({tag, "_go"}, game_over, 0);
    endtask

    initial begin
        tx = 100; ty = 100; game_restart = 1'b0;
        clear_bullets(); apply();
        #12;
        chk_reset_vals("reset");
        @(negedge clk_f);
        rst_n = 1'b1;
        model_reset();

        // Just above the hitbox, then just inside its top edge.
        put(0, 115, 99); cycle();
        chk("near_miss_hit", hit_pulse, 0);
        put(0, 115, 100); cycle();
        chk("first_hit_pulse", hit_pulse, 1);
        chk("first_hit_kill", bullet_kill, 8'h01);
        chk("first_hit_lives", tank_lives, 2);
        chk("first_hit_state", tank_state, 1);
        clear_bullets(); cycle();
        chk("pulse_one_cycle", hit_pulse, 0);

        // Walk through explosion to the first invulnerable frame, absorb one bullet.
        while (edge_n - origin < 31) cycle();
        chk("respawn_pulse", respawn_req, 1);
        put(6, 110, 110); cycle();
        chk("absorb_kill", bullet_kill, 8'h40);
        chk("absorb_lives", tank_lives, 2);
        clear_bullets();
        while (edge_n - origin < 150) cycle();
        put(7, 100, 129); cycle();
        chk("final_absorb_kill", bullet_kill, 8'h80);
        chk("final_absorb_hit", hit_pulse, 0);
        chk("final_absorb_state", tank_state, 0);
        run_until_alive();

        // Right-edge boundary: x=129 inside, x=130 outside.
        put(3, 129, 110); put(4, 130, 110); cycle();
        chk("edge_kill", bullet_kill, 8'h08);
        chk("edge_lives", tank_lives, 1);
        run_until_alive();

        // Tank at x=1000: the hitbox must not wrap past 1023; last life goes.
        tx = 1000; put(1, 1010, 110); cycle();
        chk("nowrap_kill", bullet_kill, 8'h02);
        chk("nowrap_lives", tank_lives, 0);
        clear_bullets();
        for (int k = 0; k < 32; k++) cycle();
        chk("gameover_flag", game_over, 1);
        for (int k = 0; k < 10; k++) begin rand_bullets(); put(0, 1005, 105); cycle(); end
        chk("gameover_kill", bullet_kill, 0);
        chk("gameover_state", tank_state, 4);

        // Restart from game over.
        clear_bullets(); tx = 100; game_restart = 1'b1; cycle();
        game_restart = 1'b0;
        chk("restart_lives", tank_lives, LIVES);
        chk("restart_state", tank_state, 2);
        cycle();
        chk("restart_resp", respawn_req, 1);
        chk("restart_invuln", tank_state, 3);
        run_until_alive();

        // Two simultaneous hits cost one life.
        put(2, 105, 105); put(5, 120, 125); cycle();
        chk("multi_kill", bullet_kill, 8'h24);
        chk("multi_lives", tank_lives, 2);
        clear_bullets();
        for (int k = 0; k < 5; k++) cycle();

        // Asynchronous reset in the middle of the explosion.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk_f);
        rst_n = 1'b1;
        model_reset();

        // Random play including restarts requested in any state.
        for (int k = 0; k < 3000; k++) begin
            if (k % 16 == 0) begin tx = $urandom_range(0, 1023); ty = $urandom_range(0, 1023); end
            rand_bullets();
            game_restart = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_tank_hit.md
Name: player_tank_hit

Overview:
- Receiving end of the enemy bullet path: consumes the packed enemy bullet position/exist buses and decides whether the player tank is hit.
- On a hit it kills the bullet(s), drops a life, runs explosion → respawn → invulnerability → alive, and reports game over.
- Sits beside the player tank movement logic in the frame-rate (clk_f) domain.
- Its bullet_kill mask feeds back into each enemy bullet's exist clear.

Parameters:
- NUM_BULLETS, 8, number of enemy bullets on the packed buses (10 bits per coordinate each).
- TANK_SIZE, 30, tank hitbox edge in pixels.
- LIVES_INIT, 3, lives loaded at reset and on restart (fits 3 bits).
- EXPLODE_FRAMES, 30, clk_f cycles spent in EXPLODE.
- INVULN_FRAMES, 120, clk_f cycles spent in INVULN.
- BLINK_SHIFT, 3, blink toggles every 2^BLINK_SHIFT INVULN cycles.

Ports:
- clk_f  in  1  frame-rate clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- tank_x  in  10  player tank top-left x.
- tank_y  in  10  player tank top-left y.
- bullet_x  in  10*NUM_BULLETS  enemy bullet x; bullet i at [10*i+:10].
- bullet_y  in  10*NUM_BULLETS  enemy bullet y; same packing as bullet_x.
- bullet_exit  in  NUM_BULLETS  per-bullet exist flag.
- game_restart  in  1  restart request; honoured only in GAMEOVER.
- tank_exit  out  1  tank present and drawn.
- tank_lives  out  3  remaining lives.
- hit_pulse  out  1  one-cycle pulse on a damaging hit.
- bullet_kill  out  NUM_BULLETS  one-cycle mask of bullets to clear.
- respawn_req  out  1  one-cycle pulse telling movement logic to reload spawn position.
- blink  out  1  display blink during INVULN.
- game_over  out  1  high while in GAMEOVER.
- tank_state  out  3  encoded FSM state, for debug/display.

Behaviour:
- Reset (async, rst_n low):
  - state ALIVE (encoding 0); tank_exit = 1; tank_lives = LIVES_INIT.
  - hit_pulse, bullet_kill, respawn_req, blink, game_over = 0; frame counter = 0.
  - Reset mid-sequence discards any sequence in progress.
- Hit term, combinational on current inputs, bullet i:
  - hit[i] = bullet_exit[i] & (bx >= tank_x) & (bx < tank_x+TANK_SIZE) & (by >= tank_y) & (by < tank_y+TANK_SIZE).
  - The sums are 11-bit so that tank_x near 1023 does not wrap.
- All outputs are registered; hit_pulse, bullet_kill and respawn_req are high for exactly one cycle after the edge that samples the hit.
- State encodings: ALIVE=0, EXPLODE=1, RESPAWN=2, INVULN=3, GAMEOVER=4.
- ALIVE, when |hit:
  - go to EXPLODE; tank_exit <= 0; tank_lives <= tank_lives-1 (saturates at 0).
  - hit_pulse <= 1; bullet_kill <= hit; counter <= 0.
  - Several simultaneous hits cost one life and kill every hitting bullet.
- EXPLODE:
  - bullets ignored; bullet_kill = 0; counter increments.
  - When counter == EXPLODE_FRAMES-1: go to GAMEOVER if tank_lives == 0, else RESPAWN.
- RESPAWN: single cycle; respawn_req <= 1; tank_exit <= 1; counter <= 0; next state INVULN.
- INVULN:
  - bullet_kill <= hit (bullets are absorbed), no life lost, hit_pulse stays 0.
  - blink = counter[BLINK_SHIFT].
  - When counter == INVULN_FRAMES-1: go to ALIVE, blink <= 0.
  - A hit on that same final cycle is still absorbed without damage.
- GAMEOVER:
  - tank_exit = 0; game_over = 1; bullet_kill = 0.
  - game_restart: tank_lives <= LIVES_INIT, game_over <= 0, next state RESPAWN.
  - game_restart is ignored in every other state.
- Latency: bullet overlap at edge N → hit_pulse/bullet_kill/tank_exit change visible after edge N. The bullet's exist clears at edge N+1 in the bullet block.
- blink is 0 outside INVULN.

Test Plan:
- Reset, tank (100,100), bullet0 at (115,99) exit=1 → no hit. Move to (115,100) → next cycle hit_pulse=1, bullet_kill=8'h01, tank_lives 3→2, tank_exit=0, tank_state=1.
- Boundary, tank (100,100): bullets at x=129 and x=130 → only x=129 hits. Tank x=1000, bullet x=1010: no wrap, hit detected.
- Bullets 2 and 5 overlap in the same cycle → bullet_kill=8'h24, single hit_pulse, lives drop by exactly 1.
- Timing after a hit: EXPLODE held 30 cycles, then respawn_req for 1 cycle and tank_exit=1. INVULN lasts 120 cycles with blink toggling every 8. An overlapping bullet there → bullet_kill set, lives unchanged. Then ALIVE.
- Start lives=1, take a hit → after 30 cycles game_over=1 and game_over stays 1 under further bullets. game_restart → lives=3, respawn_req pulse, INVULN.
- Assert rst_n low asynchronously mid-EXPLODE → outputs go to reset values immediately: tank_exit=1, lives=3, state ALIVE.
